// File: rtl/spike_window_decoder.sv
// spike_window_decoder
//
// Readout stage for a two-neuron spiking network. Spikes from each neuron
// are counted over back-to-back windows of WIN_CYCLES clock edges. At the
// end of each window a winner class is declared and the counts plus the
// winner are offered through a one-entry valid/ready output register.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A
// result transfers on any rising edge where out_valid && out_ready. While
// out_valid=1 and out_ready=0, every output field is held stable. out_valid
// never drops without a transfer, except on reset.
//
// Optional feature macro: SPK_DEC_TTFS_EN. When it is defined, the block
// adds the out_first0/out_first1 outputs. Each one holds the window index of
// that neuron's first spike, or all-ones if the neuron did not spike.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   enable      run windows while high; low aborts the current window
//   n0_spike    one-cycle spike pulse from neuron 0
//   n1_spike    one-cycle spike pulse from neuron 1
//   out_valid   output register holds a result
//   out_ready   consumer accepts the result
//   out_cnt0    neuron 0 spike count of the reported window (saturating)
//   out_cnt1    neuron 1 spike count of the reported window (saturating)
//   out_winner  0 = tie/undecided, 1 = neuron 0, 2 = neuron 1
//   out_first0  (SPK_DEC_TTFS_EN) index of neuron 0's first spike
//   out_first1  (SPK_DEC_TTFS_EN) index of neuron 1's first spike
//   overrun     sticky: a completed result was dropped
//   state       FSM state (0 = IDLE, 1 = COUNT), exposed for debug

module spike_window_decoder #(
    parameter int WIN_CYCLES = 256,
    parameter int CNT_W      = 16,
    parameter int MARGIN     = 2,
    localparam int IDX_W     = $clog2(WIN_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             n0_spike,
    input  logic             n1_spike,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt0,
    output logic [CNT_W-1:0] out_cnt1,
    output logic [1:0]       out_winner,
`ifdef SPK_DEC_TTFS_EN
    output logic [IDX_W-1:0] out_first0,
    output logic [IDX_W-1:0] out_first1,
`endif
    output logic             overrun,
    output logic             state
);

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W:0]   MARGIN_X = (CNT_W + 1)'(MARGIN);

    state_t           st, st_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic [CNT_W-1:0] cnt0_nx, cnt1_nx;
    logic [CNT_W:0]   w0, w1;
    logic [1:0]       winner_nx;
    logic             counting, win_done, load;

    assign state = st;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_next;
    end

    // Next-state logic.
    always_comb begin
        st_next = st;
        case (st)
            IDLE:    if (enable)  st_next = COUNT;
            COUNT:   if (!enable) st_next = IDLE;
            default: st_next = IDLE;
        endcase
    end

    assign counting = (st == COUNT) && enable;
    assign win_done = counting && (idx == IDX_LAST);

    // Saturating increments. The final window counts include the spikes
    // seen on the completion edge, so the result is taken from these values.
    assign cnt0_nx = (n0_spike && (cnt0 != CNT_MAX)) ? cnt0 + CNT_W'(1) : cnt0;
    assign cnt1_nx = (n1_spike && (cnt1 != CNT_MAX)) ? cnt1 + CNT_W'(1) : cnt1;

    // Compare at CNT_W+1 bits so that count + MARGIN cannot wrap.
    assign w0 = {1'b0, cnt0_nx};
    assign w1 = {1'b0, cnt1_nx};

    always_comb begin
        winner_nx = 2'd0;
        if (w0 >= w1 + MARGIN_X)      winner_nx = 2'd1;
        else if (w1 >= w0 + MARGIN_X) winner_nx = 2'd2;
    end

    // Window counters. They are cleared in IDLE, on an abort and at window
    // completion, so the next window starts with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (counting && !win_done) begin
            idx  <= idx + IDX_W'(1);
            cnt0 <= cnt0_nx;
            cnt1 <= cnt1_nx;
        end else begin
            idx  <= '0;
            cnt0 <= '0;
            cnt1 <= '0;
        end
    end

    // A completed result is accepted only if the single output slot is
    // empty or is being drained on the same edge. Otherwise it is dropped.
    assign load = win_done && (!out_valid || out_ready);

`ifdef SPK_DEC_TTFS_EN
    // first* == all-ones means "no spike yet". A spike on the last index
    // also writes all-ones, which reads the same way.
    logic [IDX_W-1:0] first0, first1, first0_nx, first1_nx;

    assign first0_nx = (n0_spike && (first0 == '1)) ? idx : first0;
    assign first1_nx = (n1_spike && (first1 == '1)) ? idx : first1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first0 <= '1;
            first1 <= '1;
        end else if (counting && !win_done) begin
            first0 <= first0_nx;
            first1 <= first1_nx;
        end else begin
            first0 <= '1;
            first1 <= '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_first0 <= '0;
            out_first1 <= '0;
        end else if (load) begin
            out_first0 <= first0_nx;
            out_first1 <= first1_nx;
        end
    end
`endif

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_cnt0   <= '0;
            out_cnt1   <= '0;
            out_winner <= 2'd0;
            overrun    <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_cnt0   <= cnt0_nx;
            out_cnt1   <= cnt1_nx;
            out_winner <= winner_nx;
        end else if (win_done) begin
            overrun    <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_window_decoder.sv
// Self-checking bench for spike_window_decoder.
//
// Two instances share the same inputs:
//   dut_a  WIN_CYCLES=16, CNT_W=16  (counts never saturate)
//   dut_b  WIN_CYCLES=16, CNT_W=3   (counts saturate at 7)
// The reference model records each window's spikes in queues. At completion
// it sums them, clamps the sums and applies the winner rule with integers.
module tb_spike_window_decoder;

    localparam int WIN   = 16;
    localparam int MAR   = 2;
    localparam int IDX_W = $clog2(WIN);

    logic clk = 1'b0;
    logic rst_n, enable, n0_spike, n1_spike, out_ready;

    logic        valid_a, ovr_a, state_a;
    logic [15:0] c0_a, c1_a;
    logic [1:0]  w_a;
    logic        valid_b, ovr_b, state_b;
    logic [2:0]  c0_b, c1_b;
    logic [1:0]  w_b;
`ifdef SPK_DEC_TTFS_EN
    logic [IDX_W-1:0] f0_a, f1_a, f0_b, f1_b;
`endif

    always #5 clk = ~clk;

    spike_window_decoder #(.WIN_CYCLES(WIN), .CNT_W(16), .MARGIN(MAR)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .n0_spike(n0_spike), .n1_spike(n1_spike),
        .out_valid(valid_a), .out_ready(out_ready),
        .out_cnt0(c0_a), .out_cnt1(c1_a), .out_winner(w_a),
`ifdef SPK_DEC_TTFS_EN
        .out_first0(f0_a), .out_first1(f1_a),
`endif
        .overrun(ovr_a), .state(state_a)
    );

    spike_window_decoder #(.WIN_CYCLES(WIN), .CNT_W(3), .MARGIN(MAR)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .n0_spike(n0_spike), .n1_spike(n1_spike),
        .out_valid(valid_b), .out_ready(out_ready),
        .out_cnt0(c0_b), .out_cnt1(c1_b), .out_winner(w_b),
`ifdef SPK_DEC_TTFS_EN
        .out_first0(f0_b), .out_first1(f1_b),
`endif
        .overrun(ovr_b), .state(state_b)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_cmp = 0;
    int n_bad = 0;

    bit m_run;
    bit q0[$];
    bit q1[$];
    bit m_valid, m_ovr;
    int m_c0[2], m_c1[2], m_w[2];
    int m_f0, m_f1;
    int sat_max[2] = '{65535, 7};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int winner_of(input int a, input int b);
        if (a >= b + MAR) return 1;
        if (b >= a + MAR) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_run = 0;
        q0.delete();
        q1.delete();
        m_valid = 0;
        m_ovr = 0;
        for (int i = 0; i < 2; i++) begin
            m_c0[i] = 0; m_c1[i] = 0; m_w[i] = 0;
        end
        m_f0 = 0;
        m_f1 = 0;
    endtask

    // Advances the model across one rising edge with the given inputs.
    task automatic model_step(input bit en, input bit s0, input bit s1, input bit rdy);
        bit done;
        int t0, t1, f0, f1;
        done = 0;
        t0 = 0; t1 = 0;
        f0 = (1 << IDX_W) - 1;
        f1 = (1 << IDX_W) - 1;
        if (!m_run) begin
            if (en) m_run = 1;
        end else if (!en) begin
            m_run = 0;
            q0.delete();
            q1.delete();
        end else begin
            q0.push_back(s0);
            q1.push_back(s1);
            if (q0.size() == WIN) begin
                done = 1;
                for (int i = WIN - 1; i >= 0; i--) begin
                    t0 += int'(q0[i]);
                    t1 += int'(q1[i]);
                    if (q0[i]) f0 = i;
                    if (q1[i]) f1 = i;
                end
                q0.delete();
                q1.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                for (int k = 0; k < 2; k++) begin
                    m_c0[k] = (t0 > sat_max[k]) ? sat_max[k] : t0;
                    m_c1[k] = (t1 > sat_max[k]) ? sat_max[k] : t1;
                    m_w[k]  = winner_of(m_c0[k], m_c1[k]);
                end
                m_f0 = f0;
                m_f1 = f1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("valid_a",  32'(valid_a), 32'(m_valid));
        check("cnt0_a",   32'(c0_a),    32'(m_c0[0]));
        check("cnt1_a",   32'(c1_a),    32'(m_c1[0]));
        check("winner_a", 32'(w_a),     32'(m_w[0]));
        check("overrun_a",32'(ovr_a),   32'(m_ovr));
        check("valid_b",  32'(valid_b), 32'(m_valid));
        check("cnt0_b",   32'(c0_b),    32'(m_c0[1]));
        check("cnt1_b",   32'(c1_b),    32'(m_c1[1]));
        check("winner_b", 32'(w_b),     32'(m_w[1]));
        check("overrun_b",32'(ovr_b),   32'(m_ovr));
`ifdef SPK_DEC_TTFS_EN
        check("first0_a", 32'(f0_a), 32'(m_f0));
        check("first1_a", 32'(f1_a), 32'(m_f1));
        check("first0_b", 32'(f0_b), 32'(m_f0));
        check("first1_b", 32'(f1_b), 32'(m_f1));
`endif
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive inputs, advance the model, then check
    // at the next falling edge.
    task automatic cycle(input bit en, input bit s0, input bit s1, input bit rdy);
        enable = en; n0_spike = s0; n1_spike = s1; out_ready = rdy;
        model_step(en, s0, s1, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic random_cycles(input int n, input int en_pct, input int rdy_pct);
        int p0, p1;
        p0 = $urandom_range(0, 99);
        p1 = $urandom_range(0, 99);
        for (int i = 0; i < n; i++) begin
            if (i % WIN == 0) begin
                p0 = $urandom_range(0, 99);
                p1 = $urandom_range(0, 99);
            end
            cycle($urandom_range(0, 99) < en_pct,
                  $urandom_range(0, 99) < p0,
                  $urandom_range(0, 99) < p1,
                  $urandom_range(0, 99) < rdy_pct);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; n0_spike = 1'b0; n1_spike = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // n0 spiking every cycle with the consumer always ready.
        for (int i = 0; i < 3 * WIN + 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);

        // Random spikes with enable held high and the consumer sometimes ready.
        random_cycles(300, 100, 50);

        // Consumer stalled across several completions, then drained.
        random_cycles(3 * WIN + 5, 100, 0);
        random_cycles(10, 100, 100);

        // Frequent aborts and random readiness.
        random_cycles(300, 93, 60);

        // Abort after 8 counted cycles, then a clean window.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < WIN + 2; i++) cycle(1'b1, i < 3, 1'b1, 1'b1);

        // Reset asserted mid-window: the outputs clear at once.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        random_cycles(80, 100, 70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
